uart_rx_frame_timer: RTL and testbench

Parametrised oversampling timer for the UART receiver. It generates the edge and bit counters and the mid-bit sample strobes, and flags the end of each frame. It supports any prescale in range, data lengths of 5–9 bits, optional parity and optional two stop bits. It sits between the RX FSM, which drives `edge_cnt_enable`, and the data/parity/stop samplers, which consume `sample_stb` and `bit_cnt`.

---
 rtl/uart_rx_pkg.sv | 21 ++
 rtl/uart_rx_frame_timer_if.sv | 41 ++++
 rtl/uart_rx_cfg_shadow.sv | 40 ++++
 rtl/uart_rx_frame_timer.sv | 89 ++++++++
 tb/tb_uart_rx_frame_timer.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_pkg.sv
// Shared constants, types and clamp helper for the UART receive path.
package uart_rx_pkg;

  localparam int MIN_PRESCALE = 4;
  localparam int MIN_DATA_LEN = 5;
  localparam int MAX_DATA_LEN = 9;
  localparam int BIT_CNT_W    = 4;

  // Mid-bit sample offsets relative to P>>1, in sample_idx order.
  localparam int SAMPLE_OFS [3] = '{-1, 0, 1};

  typedef logic [BIT_CNT_W-1:0] bit_cnt_t;
  typedef logic [1:0]           sample_idx_t;

  function automatic bit_cnt_t clamp_data_len(input logic [3:0] len);
    if (len < 4'(MIN_DATA_LEN)) return bit_cnt_t'(MIN_DATA_LEN);
    if (len > 4'(MAX_DATA_LEN)) return bit_cnt_t'(MAX_DATA_LEN);
    return bit_cnt_t'(len);
  endfunction

endpackage

// File: rtl/uart_rx_frame_timer_if.sv
// Control/status bundle between the RX FSM (master) and the frame timer (slave).
// The stop2 signal exists only when UART_RX_TWO_STOP_EN is defined.
interface uart_rx_frame_timer_if import uart_rx_pkg::*; #(
  parameter int PRESCALE_W = 6
);

  logic [PRESCALE_W-1:0] prescale;
  logic [3:0]            data_len;
  logic                  PAR_EN;
`ifdef UART_RX_TWO_STOP_EN
  logic                  stop2;
`endif
  logic                  edge_cnt_enable;
  logic [PRESCALE_W-1:0] edge_cnt;
  bit_cnt_t              bit_cnt;
  logic                  edge_cnt_max;
  logic                  sample_stb;
  sample_idx_t           sample_idx;
  logic                  frame_done;

`ifdef UART_RX_TWO_STOP_EN
  modport master (
    output prescale, data_len, PAR_EN, stop2, edge_cnt_enable,
    input  edge_cnt, bit_cnt, edge_cnt_max, sample_stb, sample_idx, frame_done
  );
  modport slave (
    input  prescale, data_len, PAR_EN, stop2, edge_cnt_enable,
    output edge_cnt, bit_cnt, edge_cnt_max, sample_stb, sample_idx, frame_done
  );
`else
  modport master (
    output prescale, data_len, PAR_EN, edge_cnt_enable,
    input  edge_cnt, bit_cnt, edge_cnt_max, sample_stb, sample_idx, frame_done
  );
  modport slave (
    input  prescale, data_len, PAR_EN, edge_cnt_enable,
    output edge_cnt, bit_cnt, edge_cnt_max, sample_stb, sample_idx, frame_done
  );
`endif

endinterface

// File: rtl/uart_rx_cfg_shadow.sv
// Clamps the frame configuration and holds it frozen while the timer runs;
// exports the effective prescale and the index of the last bit in the frame.
module uart_rx_cfg_shadow import uart_rx_pkg::*; #(
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk_RX,
  input  logic                  rst,
  input  logic                  load,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [3:0]            data_len,
  input  logic                  PAR_EN,
  input  logic                  stop2,
  output logic [PRESCALE_W-1:0] p_eff,
  output bit_cnt_t              last_bit
);

  logic [PRESCALE_W-1:0] p_q;
  bit_cnt_t              len_q;
  logic                  par_q;
  logic                  stop2_q;

  always_ff @(posedge clk_RX or negedge rst) begin
    if (!rst) begin
      p_q     <= PRESCALE_W'(MIN_PRESCALE);
      len_q   <= bit_cnt_t'(MIN_DATA_LEN);
      par_q   <= 1'b0;
      stop2_q <= 1'b0;
    end else if (load) begin
      p_q     <= (prescale < PRESCALE_W'(MIN_PRESCALE)) ? PRESCALE_W'(MIN_PRESCALE) : prescale;
      len_q   <= clamp_data_len(data_len);
      par_q   <= PAR_EN;
      stop2_q <= stop2;
    end
  end

  // Last index = frame bits - 1 = data + parity + stop bits (start bit is index 0).
  assign p_eff    = p_q;
  assign last_bit = len_q + bit_cnt_t'(par_q) + bit_cnt_t'(1) + bit_cnt_t'(stop2_q);

endmodule

// File: rtl/uart_rx_frame_timer.sv
// Oversampling edge/bit counters, mid-bit sample strobes and end-of-frame pulse.
// Defining UART_RX_TWO_STOP_EN adds the stop2 input for two-stop-bit frames.
module uart_rx_frame_timer import uart_rx_pkg::*; #(
  parameter int PRESCALE_W = 6
) (
  input  logic                   clk_RX,
  input  logic                   rst,
  uart_rx_frame_timer_if.slave   bus
);

  logic [PRESCALE_W-1:0] p_eff;
  bit_cnt_t              last_bit;
  logic                  stop2_sel;
  logic [PRESCALE_W-1:0] edge_q;
  bit_cnt_t              bit_q;
  logic                  done_q;
  logic [PRESCALE_W-1:0] p_max;
  logic [PRESCALE_W-1:0] mid;
  logic                  at_max;
  logic                  stb;
  sample_idx_t           idx;

`ifdef UART_RX_TWO_STOP_EN
  assign stop2_sel = bus.stop2;
`else
  assign stop2_sel = 1'b0;
`endif

  uart_rx_cfg_shadow #(.PRESCALE_W(PRESCALE_W)) u_cfg_shadow (
    .clk_RX   (clk_RX),
    .rst      (rst),
    .load     (~bus.edge_cnt_enable),
    .prescale (bus.prescale),
    .data_len (bus.data_len),
    .PAR_EN   (bus.PAR_EN),
    .stop2    (stop2_sel),
    .p_eff    (p_eff),
    .last_bit (last_bit)
  );

  assign p_max  = p_eff - PRESCALE_W'(1);
  assign mid    = p_eff >> 1;
  assign at_max = (edge_q == p_max);

  always_ff @(posedge clk_RX or negedge rst) begin
    if (!rst) begin
      edge_q <= '0;
      bit_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (!bus.edge_cnt_enable) begin
        edge_q <= '0;
        bit_q  <= '0;
      end else if (at_max) begin
        edge_q <= '0;
        if (bit_q == last_bit) begin
          bit_q  <= '0;
          done_q <= 1'b1;
        end else begin
          bit_q <= bit_q + bit_cnt_t'(1);
        end
      end else begin
        edge_q <= edge_q + PRESCALE_W'(1);
      end
    end
  end

  always_comb begin
    stb = 1'b0;
    idx = '0;
    if (bus.edge_cnt_enable) begin
      for (int i = 0; i < 3; i++) begin
        if (int'(edge_q) == int'(mid) + SAMPLE_OFS[i]) begin
          stb = 1'b1;
          idx = 2'(i);
        end
      end
    end
  end

  assign bus.edge_cnt     = edge_q;
  assign bus.bit_cnt      = bit_q;
  assign bus.edge_cnt_max = at_max;
  assign bus.sample_stb   = stb;
  assign bus.sample_idx   = idx;
  assign bus.frame_done   = done_q;

endmodule

// File: tb/tb_uart_rx_frame_timer.sv
// Bench for uart_rx_frame_timer: directed frames plus random runs against a
// frame-position model. Honours UART_RX_TWO_STOP_EN when defined.
module tb_uart_rx_frame_timer;

  localparam int PW = 6;
`ifdef UART_RX_TWO_STOP_EN
  localparam int FRAME_P16 = 176;
`else
  localparam int FRAME_P16 = 160;
`endif

  logic clk_RX = 1'b0;
  logic rst    = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // Model: position within frame in enabled cycles, plus the frozen config.
  int m_k    = 0;
  int m_p    = 4;
  int m_l    = 5;
  int m_par  = 0;
  int m_s    = 1;
  int m_done = 0;

  uart_rx_frame_timer_if #(.PRESCALE_W(PW)) bus ();

  uart_rx_frame_timer #(.PRESCALE_W(PW)) dut (
    .clk_RX (clk_RX),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 clk_RX = ~clk_RX;

  task automatic checkOutput(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int clampP(input int v);
    if (v < 4) return 4;
    return v;
  endfunction

  function automatic int clampL(input int v);
    if (v < 5) return 5;
    if (v > 9) return 9;
    return v;
  endfunction

  task automatic applyStimulus(input int p, input int l, input int par, input int s2, input int en);
    bus.prescale        = PW'(p);
    bus.data_len        = 4'(l);
    bus.PAR_EN          = 1'(par);
`ifdef UART_RX_TWO_STOP_EN
    bus.stop2           = 1'(s2);
`endif
    bus.edge_cnt_enable = 1'(en);
  endtask

  task automatic modelUpdate();
    int frame_cycles;
    m_done = 0;
    if (!rst) begin
      m_k = 0; m_p = 4; m_l = 5; m_par = 0; m_s = 1;
    end else if (bus.edge_cnt_enable) begin
      frame_cycles = (1 + m_l + m_par + m_s) * m_p;
      if (m_k + 1 == frame_cycles) begin
        m_k    = 0;
        m_done = 1;
      end else begin
        m_k++;
      end
    end else begin
      m_k   = 0;
      m_p   = clampP(int'(bus.prescale));
      m_l   = clampL(int'(bus.data_len));
      m_par = bus.PAR_EN ? 1 : 0;
`ifdef UART_RX_TWO_STOP_EN
      m_s   = bus.stop2 ? 2 : 1;
`else
      m_s   = 1;
`endif
    end
  endtask

  task automatic checkModel();
    int e, b, mid, stb, idx;
    e   = m_k % m_p;
    b   = m_k / m_p;
    mid = m_p / 2;
    stb = (bus.edge_cnt_enable && e >= mid - 1 && e <= mid + 1) ? 1 : 0;
    idx = (stb != 0) ? e - (mid - 1) : 0;
    checkOutput("edge_cnt", int'(bus.edge_cnt), e);
    checkOutput("bit_cnt", int'(bus.bit_cnt), b);
    checkOutput("edge_cnt_max", int'(bus.edge_cnt_max), (e == m_p - 1) ? 1 : 0);
    checkOutput("sample_stb", int'(bus.sample_stb), stb);
    checkOutput("sample_idx", int'(bus.sample_idx), idx);
    checkOutput("frame_done", int'(bus.frame_done), m_done);
  endtask

  task automatic step();
    @(posedge clk_RX);
    modelUpdate();
    #1;
    checkModel();
  endtask

  task automatic configure(input int p, input int l, input int par, input int s2);
    applyStimulus(p, l, par, s2, 0);
    step();
    applyStimulus(p, l, par, s2, 1);
  endtask

  // Counts enabled edges until frame_done is seen, bounded by a cycle budget.
  task automatic runFrame(input string tag, input int exp);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (bus.frame_done !== 1'b1 && n < 2000);
    checkOutput(tag, n, exp);
  endtask

  initial begin
    applyStimulus(8, 8, 0, 0, 0);
    #2;
    checkModel();
    repeat (2) step();
    rst = 1'b1;

    configure(8, 8, 0, 0);
    runFrame("frame_p8_l8", 80);
    repeat (5) step();

    configure(16, 7, 1, 1);
    runFrame("frame_p16_l7_par", FRAME_P16);

    configure(5, 9, 1, 0);
    runFrame("frame_p5_l9_par", 60);
    configure(2, 5, 0, 0);
    runFrame("frame_presc2", 28);
    configure(4, 5, 0, 0);
    runFrame("frame_presc4", 28);

    configure(8, 8, 0, 0);
    repeat (38) step();
    checkOutput("drop_at_bit", int'(bus.bit_cnt), 4);
    checkOutput("drop_at_edge", int'(bus.edge_cnt), 6);
    applyStimulus(8, 8, 0, 0, 0);
    step();
    checkOutput("drop_bit_clear", int'(bus.bit_cnt), 0);
    applyStimulus(8, 8, 0, 0, 1);
    runFrame("frame_after_drop", 80);

    configure(8, 8, 0, 0);
    repeat (20) step();
    applyStimulus(32, 8, 0, 0, 1);
    runFrame("frame_presc_frozen", 60);
    applyStimulus(32, 8, 0, 0, 0);
    step();
    applyStimulus(32, 8, 0, 0, 1);
    runFrame("frame_presc32", 320);

    configure(8, 8, 0, 0);
    repeat (58) step();
    checkOutput("rst_at_bit", int'(bus.bit_cnt), 7);
    rst = 1'b0;
    modelUpdate();
    #1;
    checkOutput("rst_edge_cnt", int'(bus.edge_cnt), 0);
    checkOutput("rst_bit_cnt", int'(bus.bit_cnt), 0);
    checkOutput("rst_sample_stb", int'(bus.sample_stb), 0);
    checkOutput("rst_frame_done", int'(bus.frame_done), 0);
    applyStimulus(8, 8, 0, 0, 0);
    repeat (2) step();
    rst = 1'b1;
    repeat (90) step();

    for (int seg = 0; seg < 40; seg++) begin
      int p, l, par, s2, len;
      p   = int'($urandom_range(0, 20));
      l   = int'($urandom_range(0, 15));
      par = int'($urandom_range(0, 1));
      s2  = int'($urandom_range(0, 1));
      applyStimulus(p, l, par, s2, 0);
      repeat ($urandom_range(1, 3)) step();
      applyStimulus(p, l, par, s2, 1);
      len = int'($urandom_range(1, 300));
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 39) == 0)
          applyStimulus(int'($urandom_range(0, 20)), int'($urandom_range(0, 15)),
                        int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), 1);
        step();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
